// File: rtl/arc_arrival_engine_if.sv
// Handshake/bus bundle for arc_arrival_engine: table write port, pin-arrival
// stream and gate result. ARC_MIN_EN adds the early-arrival result signals.
interface arc_arrival_engine_if #(
  parameter int unsigned NUM_CELLS = 32,
  parameter int unsigned MAX_PINS  = 8,
  parameter int unsigned DLY_W     = 16,
  parameter int unsigned ARR_W     = 24
);
  localparam int unsigned CW = $clog2(NUM_CELLS);
  localparam int unsigned PW = $clog2(MAX_PINS);

  logic             lib_we;
  logic [CW-1:0]    lib_cell;
  logic [PW-1:0]    lib_pin;
  logic [DLY_W-1:0] lib_dly;
  logic             lib_clr;

  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_cell;
  logic [PW-1:0]    in_pin;
  logic [ARR_W-1:0] in_arr;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [ARR_W-1:0] out_arr;
  logic [PW-1:0]    out_crit;
  logic             out_err;
`ifdef ARC_MIN_EN
  logic [ARR_W-1:0] out_arr_min;
  logic [PW-1:0]    out_crit_min;
`endif

  modport master (
    output lib_we, lib_cell, lib_pin, lib_dly, lib_clr,
    output in_valid, in_cell, in_pin, in_arr, in_last, out_ready,
    input  in_ready, out_valid, out_arr, out_crit, out_err
`ifdef ARC_MIN_EN
    , input out_arr_min, out_crit_min
`endif
  );

  modport slave (
    input  lib_we, lib_cell, lib_pin, lib_dly, lib_clr,
    input  in_valid, in_cell, in_pin, in_arr, in_last, out_ready,
    output in_ready, out_valid, out_arr, out_crit, out_err
`ifdef ARC_MIN_EN
    , output out_arr_min, out_crit_min
`endif
  );
endinterface

// File: rtl/arc_arrival_engine.sv
// Gate arrival evaluator: out = max over pins of (pin arrival + arc delay).
// Define ARC_MIN_EN to also track the minimum sum (early/hold arrival).
module arc_arrival_engine #(
  parameter int unsigned NUM_CELLS = 32,
  parameter int unsigned MAX_PINS  = 8,
  parameter int unsigned DLY_W     = 16,
  parameter int unsigned ARR_W     = 24
) (
  input logic               clk,
  input logic               rst_n,
  arc_arrival_engine_if.slave bus
);
  localparam int unsigned CW      = $clog2(NUM_CELLS);
  localparam int unsigned PW      = $clog2(MAX_PINS);
  localparam int unsigned ENTRIES = NUM_CELLS * MAX_PINS;
  localparam int unsigned IW      = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q;
  logic [DLY_W-1:0] dly_mem [ENTRIES];
  logic [ENTRIES-1:0] vld_q;
  logic [CW-1:0]    cell_q;
  logic [ARR_W-1:0] acc_q;
  logic [PW-1:0]    crit_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef ARC_MIN_EN
  logic [ARR_W-1:0] min_q;
  logic [PW-1:0]    crit_min_q;
`endif

  logic [CW-1:0]    lk_cell;
  logic [IW-1:0]    lk_idx;
  logic [IW-1:0]    wr_idx;
  logic [DLY_W-1:0] lk_dly;
  logic [ARR_W:0]   sum_wide;
  logic [ARR_W-1:0] sum;
  logic             beat_err;
  logic             accept;

  // Lookup is a combinational read of the pre-edge table, so a write to the
  // same entry in the same cycle is seen only by later beats.
  always_comb begin
    lk_cell  = (state_q == IDLE) ? bus.in_cell : cell_q;
    lk_idx   = IW'(lk_cell) * IW'(MAX_PINS) + IW'(bus.in_pin);
    wr_idx   = IW'(bus.lib_cell) * IW'(MAX_PINS) + IW'(bus.lib_pin);
    lk_dly   = vld_q[lk_idx] ? dly_mem[lk_idx] : '0;
    sum_wide = {1'b0, bus.in_arr} + {{(ARR_W + 1 - DLY_W){1'b0}}, lk_dly};
    sum      = sum_wide[ARR_W] ? '1 : sum_wide[ARR_W-1:0];
    beat_err = !vld_q[lk_idx] || ((state_q == ACCUM) && (bus.in_cell != cell_q));
    accept   = bus.in_valid && in_ready_q;
  end

  always_ff @(posedge clk) begin
    if (bus.lib_we) dly_mem[wr_idx] <= bus.lib_dly;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      if (bus.lib_clr) vld_q <= '0;
      if (bus.lib_we)  vld_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cell_q      <= '0;
      acc_q       <= '0;
      crit_q      <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ARC_MIN_EN
      min_q       <= '0;
      crit_min_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            cell_q <= bus.in_cell;
            acc_q  <= sum;
            crit_q <= bus.in_pin;
            err_q  <= beat_err;
`ifdef ARC_MIN_EN
            min_q      <= sum;
            crit_min_q <= bus.in_pin;
`endif
            if (bus.in_last) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (sum > acc_q) begin
              acc_q  <= sum;
              crit_q <= bus.in_pin;
            end
`ifdef ARC_MIN_EN
            if (sum < min_q) begin
              min_q      <= sum;
              crit_min_q <= bus.in_pin;
            end
`endif
            err_q <= err_q | beat_err;
            if (bus.in_last) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_arr   = acc_q;
  assign bus.out_crit  = crit_q;
  assign bus.out_err   = err_q;
`ifdef ARC_MIN_EN
  assign bus.out_arr_min  = min_q;
  assign bus.out_crit_min = crit_min_q;
`endif
endmodule

// File: tb/tb_arc_arrival_engine.sv
// Self-checking bench for arc_arrival_engine: directed vector table, corner
// sequences, and randomized gates checked against a shadow-table model.
module tb_arc_arrival_engine;
  localparam int unsigned NC = 32, NP = 8, DW = 16, AW = 24;
  localparam longint SAT = 64'd16777215;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  arc_arrival_engine_if #(.NUM_CELLS(NC), .MAX_PINS(NP), .DLY_W(DW), .ARR_W(AW)) bus ();

  arc_arrival_engine #(.NUM_CELLS(NC), .MAX_PINS(NP), .DLY_W(DW), .ARR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      nm;
    int         nb;
    logic [4:0] c0, c1;
    logic [2:0] p0, p1;
    logic [23:0] a0, a1;
    logic [23:0] e_arr;
    logic [2:0]  e_crit;
    logic        e_err;
  } vec_t;

  vec_t vt[6];

  logic [15:0] sh_dly [NC][NP];
  bit          sh_v   [NC][NP];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic lib_write(input logic [4:0] c, input logic [2:0] p, input logic [15:0] d);
    bus.lib_we = 1'b1; bus.lib_cell = c; bus.lib_pin = p; bus.lib_dly = d;
    tick();
    bus.lib_we = 1'b0;
  endtask

  task automatic send_beat(input logic [4:0] c, input logic [2:0] p, input logic [23:0] a,
                           input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_cell = c; bus.in_pin = p; bus.in_arr = a; bus.in_last = last;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) timeout_fail("in_ready_wait");
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(input string nm, input logic [23:0] e_arr, input logic [2:0] e_crit,
                            input logic e_err, input int ready_dly);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      timeout_fail({nm, "_out_valid"});
    end else begin
      check({nm, "_arr"},  32'(bus.out_arr),  32'(e_arr));
      check({nm, "_crit"}, 32'(bus.out_crit), 32'(e_crit));
      check({nm, "_err"},  32'(bus.out_err),  32'(e_err));
    end
    repeat (ready_dly) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Reference model: lookup always via the gate's first-beat cell, strict max / min.
  task automatic run_random(input int n_gates);
    for (int g = 0; g < n_gates; g++) begin
      int          nb;
      logic [4:0]  c, bc;
      logic [2:0]  bp;
      logic [23:0] ba;
      longint      s, best, low;
      logic [2:0]  crit, crit_min;
      logic        err;
      if ($urandom_range(0, 19) == 0) begin
        bus.lib_clr = 1'b1;
        tick();
        bus.lib_clr = 1'b0;
        for (int ci = 0; ci < NC; ci++)
          for (int pi = 0; pi < NP; pi++) sh_v[ci][pi] = 1'b0;
      end
      repeat ($urandom_range(0, 3)) begin
        logic [4:0]  wc;
        logic [2:0]  wp;
        logic [15:0] wd;
        wc = 5'($urandom_range(0, 3));
        wp = 3'($urandom_range(0, 7));
        wd = 16'($urandom);
        lib_write(wc, wp, wd);
        sh_dly[wc][wp] = wd;
        sh_v[wc][wp]   = 1'b1;
      end
      nb = $urandom_range(1, 4);
      c  = 5'($urandom_range(0, 3));
      err = 1'b0; best = 0; low = 0; crit = '0; crit_min = '0;
      for (int b = 0; b < nb; b++) begin
        bc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : c;
        if (b == 0) bc = c;
        bp = 3'($urandom_range(0, 7));
        ba = ($urandom_range(0, 3) == 0) ? 24'(24'hFFFF00 + $urandom_range(0, 255))
                                         : 24'($urandom_range(0, 100000));
        s = longint'(ba) + (sh_v[c][bp] ? longint'(sh_dly[c][bp]) : 0);
        if (s > SAT) s = SAT;
        if (!sh_v[c][bp] || bc != c) err = 1'b1;
        if (b == 0 || s > best) begin best = s; crit = bp; end
        if (b == 0 || s < low)  begin low = s;  crit_min = bp; end
        repeat ($urandom_range(0, 2)) tick();
        send_beat(bc, bp, ba, (b == nb - 1));
      end
`ifdef ARC_MIN_EN
      if (bus.out_valid === 1'b1) begin
        check("rnd_min_arr",  32'(bus.out_arr_min),  32'(low));
        check("rnd_min_crit", 32'(bus.out_crit_min), 32'(crit_min));
      end
`endif
      get_result("rnd", 24'(best), crit, err, $urandom_range(0, 3));
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.lib_we = 1'b0; bus.lib_cell = '0; bus.lib_pin = '0; bus.lib_dly = '0; bus.lib_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_cell = '0; bus.in_pin = '0; bus.in_arr = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    for (int ci = 0; ci < NC; ci++)
      for (int pi = 0; pi < NP; pi++) begin sh_v[ci][pi] = 1'b0; sh_dly[ci][pi] = '0; end

    vt[0] = '{"basic",      2, 5'd4, 5'd4, 3'd0, 3'd1, 24'd1000,     24'd900,   24'd2576,     3'd1, 1'b0};
    vt[1] = '{"tie",        2, 5'd4, 5'd4, 3'd0, 3'd1, 24'd1174,     24'd1000,  24'd2676,     3'd0, 1'b0};
    vt[2] = '{"invalid",    2, 5'd7, 5'd7, 3'd0, 3'd2, 24'd100,      24'd50000, 24'd50000,    3'd2, 1'b1};
    vt[3] = '{"saturate",   1, 5'd4, 5'd4, 3'd1, 3'd1, 24'd16777000, 24'd0,     24'd16777215, 3'd1, 1'b0};
    vt[4] = '{"mismatch",   2, 5'd4, 5'd7, 3'd0, 3'd1, 24'd10,       24'd20,    24'd1696,     3'd1, 1'b1};
    vt[5] = '{"first_wins", 2, 5'd4, 5'd4, 3'd1, 3'd0, 24'd5000,     24'd100,   24'd6676,     3'd1, 1'b0};

    repeat (3) tick();
    check("rst_in_ready",  32'(bus.in_ready),  0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_arr",   32'(bus.out_arr),   0);
    check("rst_out_crit",  32'(bus.out_crit),  0);
    check("rst_out_err",   32'(bus.out_err),   0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 1);

    lib_write(5'd4, 3'd0, 16'd1502);
    lib_write(5'd4, 3'd1, 16'd1676);
    lib_write(5'd7, 3'd0, 16'd6069);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].nb == 2) send_beat(vt[i].c0, vt[i].p0, vt[i].a0, 1'b0);
      send_beat(vt[i].c1, vt[i].p1, (vt[i].nb == 2) ? vt[i].a1 : vt[i].a0, 1'b1);
      check({vt[i].nm, "_latency"}, 32'(bus.out_valid), 1);
      get_result(vt[i].nm, vt[i].e_arr, vt[i].e_crit, vt[i].e_err, 0);
    end

    // Back-pressure in DONE
    send_beat(5'd4, 3'd0, 24'd1000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("stall_in_ready",  32'(bus.in_ready),  0);
      check("stall_out_valid", 32'(bus.out_valid), 1);
      check("stall_out_arr",   32'(bus.out_arr),   2502);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stall_release_valid", 32'(bus.out_valid), 0);
    check("stall_release_ready", 32'(bus.in_ready),  1);

    // Input gap in ACCUM
    send_beat(5'd4, 3'd0, 24'd100, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check("gap_in_ready",  32'(bus.in_ready),  1);
      check("gap_out_valid", 32'(bus.out_valid), 0);
      tick();
    end
    send_beat(5'd4, 3'd1, 24'd50, 1'b1);
    get_result("gap", 24'd1726, 3'd1, 1'b0, 1);

    // Write and lookup of the same entry in one cycle: lookup sees old delay
    check("coll_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.in_cell = 5'd4; bus.in_pin = 3'd0; bus.in_arr = '0; bus.in_last = 1'b1;
    bus.lib_we = 1'b1; bus.lib_cell = 5'd4; bus.lib_pin = 3'd0; bus.lib_dly = 16'd9999;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.lib_we = 1'b0;
    get_result("coll_old", 24'd1502, 3'd0, 1'b0, 0);
    send_beat(5'd4, 3'd0, 24'd0, 1'b1);
    get_result("coll_new", 24'd9999, 3'd0, 1'b0, 0);

    // Clear and write together: the written entry survives
    bus.lib_clr = 1'b1;
    bus.lib_we = 1'b1; bus.lib_cell = 5'd4; bus.lib_pin = 3'd1; bus.lib_dly = 16'd77;
    tick();
    bus.lib_clr = 1'b0; bus.lib_we = 1'b0;
    send_beat(5'd4, 3'd0, 24'd5, 1'b1);
    get_result("clr_other", 24'd5, 3'd0, 1'b1, 0);
    send_beat(5'd4, 3'd1, 24'd5, 1'b1);
    get_result("clr_written", 24'd82, 3'd1, 1'b0, 0);

    // Reset mid-gate
    lib_write(5'd4, 3'd0, 16'd1502);
    send_beat(5'd4, 3'd0, 24'd10, 1'b0);
    send_beat(5'd4, 3'd1, 24'd20, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(bus.in_ready),  0);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("midrst_no_result", 32'(bus.out_valid), 0);
    end
    send_beat(5'd4, 3'd0, 24'd10, 1'b1);
    get_result("midrst_cleared", 24'd10, 3'd0, 1'b1, 0);

    for (int ci = 0; ci < 4; ci++)
      for (int pi = 0; pi < NP; pi++)
        if ($urandom_range(0, 7) != 0) begin
          logic [15:0] d;
          d = 16'($urandom);
          lib_write(5'(ci), 3'(pi), d);
          sh_dly[ci][pi] = d;
          sh_v[ci][pi]   = 1'b1;
        end
    run_random(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
